// File: rtl/uart_pkg.sv
//==============================================================================
// Module      : uart_pkg
// Description : Shared types and constants for the UART transmit arbiter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package uart_pkg;

    localparam logic [1:0] C_ST_IDLE      = 2'd0;
    localparam logic [1:0] C_ST_LAUNCH    = 2'd1;
    localparam logic [1:0] C_ST_WAIT_BUSY = 2'd2;
    localparam logic [1:0] C_ST_WAIT_DONE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE      = C_ST_IDLE,
        ST_LAUNCH    = C_ST_LAUNCH,
        ST_WAIT_BUSY = C_ST_WAIT_BUSY,
        ST_WAIT_DONE = C_ST_WAIT_DONE
    } arb_state_t;

    // Start, parity and stop bits wrap every data byte.
    localparam int C_FRAME_OVERHEAD    = 3;
    localparam int C_DEFAULT_DATA_BITS = 8;
    localparam int FRAME_BITS          = C_DEFAULT_DATA_BITS + C_FRAME_OVERHEAD;

    function automatic int frame_bits(input int data_bits);
        return data_bits + C_FRAME_OVERHEAD;
    endfunction

    // Low bit of client's byte within the packed req_data bus.
    function automatic int slice_lo(input int client, input int data_bits);
        return client * data_bits;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_priority_pick.sv
//==============================================================================
// Module      : rr_priority_pick
// Description : Combinational round-robin pick; first set request after last_grant.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module rr_priority_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last_grant,
    output logic                       valid,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

    localparam int ID_W = $clog2(NUM_REQ);

    int w_idx;

    // Walk offsets from farthest to nearest so the nearest set bit wins.
    always_comb begin
        valid     = 1'b0;
        grant_idx = '0;
        w_idx     = 0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            w_idx = int'(last_grant) + off;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            if (req[w_idx]) begin
                valid     = 1'b1;
                grant_idx = ID_W'(w_idx);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
//==============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin sharing of one uart_Tx between NUM_REQ byte clients.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_BITS = 8,
    parameter int TIMEOUT   = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
    output logic [NUM_REQ-1:0]             ack,
    output logic                           tx_transmit,
    output logic [DATA_BITS-1:0]           tx_data,
    input  logic                           tx_busy,
    output logic [$clog2(NUM_REQ)-1:0]     active_id,
    output logic                           frame_done,
    output logic                           tx_err
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    arb_state_t       r_state;
    logic [ID_W-1:0]  r_last_grant;
    logic [CNT_W-1:0] r_cnt;

    logic             w_valid;
    logic [ID_W-1:0]  w_grant_idx;

    rr_priority_pick #(
        .NUM_REQ    (NUM_REQ)
    ) u_pick (
        .req        (req),
        .last_grant (r_last_grant),
        .valid      (w_valid),
        .grant_idx  (w_grant_idx)
    );

    // Pulse outputs default low each cycle; only the state that owns them raises them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_last_grant <= ID_W'(NUM_REQ - 1);
            r_cnt        <= '0;
            ack          <= '0;
            tx_transmit  <= 1'b0;
            tx_data      <= '0;
            active_id    <= '0;
            frame_done   <= 1'b0;
            tx_err       <= 1'b0;
        end else begin
            ack         <= '0;
            tx_transmit <= 1'b0;
            frame_done  <= 1'b0;
            tx_err      <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_valid && !tx_busy) begin
                        tx_data          <= req_data[slice_lo(int'(w_grant_idx), DATA_BITS) +: DATA_BITS];
                        active_id        <= w_grant_idx;
                        r_last_grant     <= w_grant_idx;
                        ack[w_grant_idx] <= 1'b1;
                        tx_transmit      <= 1'b1;
                        r_state          <= ST_LAUNCH;
                    end
                end

                ST_LAUNCH: begin
                    r_cnt   <= '0;
                    r_state <= ST_WAIT_BUSY;
                end

                // A transmitter that never goes busy must not wedge the arbiter.
                ST_WAIT_BUSY: begin
                    if (tx_busy) begin
                        r_state <= ST_WAIT_DONE;
                    end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                        tx_err  <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                ST_WAIT_DONE: begin
                    if (!tx_busy) begin
                        frame_done <= 1'b1;
                        r_state    <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
//==============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Directed self-checking bench for uart_tx_arbiter with a uart_Tx model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  ack;
    logic        tx_transmit;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic [1:0]  active_id;
    logic        frame_done;
    logic        tx_err;

    logic        force_busy = 1'b0;
    logic        model_en = 1'b1;
    logic        m_busy;
    logic        m_line;
    logic [10:0] m_sh;
    int          m_idx;
    logic [10:0] cap = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign tx_busy = force_busy | m_busy;

    uart_tx_arbiter #(
        .NUM_REQ     (4),
        .DATA_BITS   (8),
        .TIMEOUT     (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .req_data    (req_data),
        .ack         (ack),
        .tx_transmit (tx_transmit),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .active_id   (active_id),
        .frame_done  (frame_done),
        .tx_err      (tx_err)
    );

    // uart_Tx model: busy for 11 cycles after the strobe, even parity, LSB first.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy <= 1'b0;
            m_line <= 1'b1;
            m_sh   <= '0;
            m_idx  <= 0;
        end else if (!m_busy) begin
            if (tx_transmit && model_en) begin
                m_sh   <= {1'b1, ^tx_data, tx_data, 1'b0};
                m_line <= 1'b0;
                m_idx  <= 1;
                m_busy <= 1'b1;
            end
        end else if (m_idx == 11) begin
            m_busy <= 1'b0;
            m_line <= 1'b1;
        end else begin
            m_line <= m_sh[m_idx];
            m_idx  <= m_idx + 1;
        end
    end

    always @(posedge clk) begin
        if (m_busy) cap <= {m_line, cap[10:1]};
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        req   = '0;
        force_busy = 1'b0;
        model_en   = 1'b1;
        tick;
        tick;
        reset = 1'b0;
    endtask

    task automatic wait_launch(input int budget, output int cyc);
        cyc = -1;
        for (int i = 1; i <= budget; i++) begin
            tick;
            if (tx_transmit === 1'b1) begin
                cyc = i;
                break;
            end
        end
        if (cyc < 0) begin
            checks++; errors++;
            $display("FAIL launch_timeout: no tx_transmit within %0d cycles", budget);
        end
    endtask

    task automatic wait_frame_done(input int budget, output int cyc);
        cyc = -1;
        for (int i = 1; i <= budget; i++) begin
            tick;
            if (frame_done === 1'b1) begin
                cyc = i;
                break;
            end
        end
        if (cyc < 0) begin
            checks++; errors++;
            $display("FAIL frame_done_timeout: no frame_done within %0d cycles", budget);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick;
        checks++; if (ack !== 4'b0000)     begin errors++; $display("FAIL reset_ack: got %b expected 0000", ack); end
        checks++; if (tx_transmit !== 1'b0) begin errors++; $display("FAIL reset_transmit: got %b expected 0", tx_transmit); end
        checks++; if (tx_data !== 8'h00)    begin errors++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
        checks++; if (active_id !== 2'd0)   begin errors++; $display("FAIL reset_active_id: got %0d expected 0", active_id); end
        checks++; if (frame_done !== 1'b0 || tx_err !== 1'b0) begin
            errors++; $display("FAIL reset_pulses: got frame_done=%b tx_err=%b expected 0 0", frame_done, tx_err);
        end
        reset = 1'b0;
    endtask

    task automatic test_single;
        do_reset;
        req_data[23:16] = 8'hA5;
        req = 4'b0100;
        tick;  // t1
        checks++; if (ack !== 4'b0100)      begin errors++; $display("FAIL single_ack: got %b expected 0100", ack); end
        checks++; if (tx_transmit !== 1'b1) begin errors++; $display("FAIL single_transmit: got %b expected 1", tx_transmit); end
        checks++; if (active_id !== 2'd2)   begin errors++; $display("FAIL single_active_id: got %0d expected 2", active_id); end
        req = '0;
        for (int t = 2; t <= 13; t++) begin
            tick;
            checks++;
            if (frame_done !== 1'b0 || ack !== 4'b0000) begin
                errors++; $display("FAIL single_quiet_t%0d: got frame_done=%b ack=%b expected 0 0000", t, frame_done, ack);
            end
        end
        tick;  // t14
        checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL single_frame_done_t14: got %b expected 1", frame_done); end
        checks++; if (cap !== 11'b1_0_10100101_0) begin errors++; $display("FAIL single_serial: got %b expected 10101001010", cap); end
        tick;
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL single_frame_done_pulse: got %b expected 0", frame_done); end
        checks++; if (tx_data !== 8'hA5)   begin errors++; $display("FAIL single_tx_data_hold: got %h expected a5", tx_data); end
    endtask

    task automatic test_round_robin;
        int cyc;
        logic [3:0] exp_ack;
        do_reset;
        req_data = 32'h44332211;
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            wait_launch(40, cyc);
            exp_ack = 4'b0001 << (g % 4);
            checks++;
            if (ack !== exp_ack) begin errors++; $display("FAIL rr_ack_%0d: got %b expected %b", g, ack, exp_ack); end
            checks++;
            if (tx_data !== 8'(8'h11 * ((g % 4) + 1))) begin
                errors++; $display("FAIL rr_data_%0d: got %h expected %h", g, tx_data, 8'(8'h11 * ((g % 4) + 1)));
            end
            // LAUNCH at t1 then t15 relative to each request cycle.
            if (g > 0) begin
                checks++;
                if (cyc !== 14) begin errors++; $display("FAIL rr_spacing_%0d: got %0d expected 14", g, cyc); end
            end
        end
        req = '0;
    endtask

    task automatic test_fairness_wrap;
        int cyc;
        do_reset;
        req = 4'b1001;
        wait_launch(5, cyc);
        checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL wrap_first: got %b expected 0001", ack); end
        wait_launch(20, cyc);
        checks++; if (ack !== 4'b1000) begin errors++; $display("FAIL wrap_second: got %b expected 1000", ack); end
        checks++; if (active_id !== 2'd3) begin errors++; $display("FAIL wrap_active_id: got %0d expected 3", active_id); end
        req = '0;
        wait_frame_done(20, cyc);
    endtask

    task automatic test_busy_gating;
        int cyc;
        do_reset;
        force_busy = 1'b1;
        req = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            tick;
            checks++;
            if (ack !== 4'b0000 || tx_transmit !== 1'b0) begin
                errors++; $display("FAIL busy_hold_%0d: got ack=%b transmit=%b expected 0000 0", i, ack, tx_transmit);
            end
        end
        force_busy = 1'b0;
        tick;
        checks++;
        if (ack !== 4'b0001 || tx_transmit !== 1'b1) begin
            errors++; $display("FAIL busy_release: got ack=%b transmit=%b expected 0001 1", ack, tx_transmit);
        end
        req = '0;
        wait_frame_done(20, cyc);
    endtask

    task automatic test_timeout;
        int cyc;
        do_reset;
        model_en = 1'b0;
        req = 4'b0010;
        tick;  // t1
        checks++; if (tx_transmit !== 1'b1) begin errors++; $display("FAIL to_transmit: got %b expected 1", tx_transmit); end
        req = '0;
        for (int t = 2; t <= 5; t++) begin
            tick;
            checks++;
            if (tx_err !== 1'b0 || frame_done !== 1'b0) begin
                errors++; $display("FAIL to_early_t%0d: got tx_err=%b frame_done=%b expected 0 0", t, tx_err, frame_done);
            end
        end
        tick;  // t6
        checks++;
        if (tx_err !== 1'b1 || frame_done !== 1'b0) begin
            errors++; $display("FAIL to_err_t6: got tx_err=%b frame_done=%b expected 1 0", tx_err, frame_done);
        end
        model_en = 1'b1;
        req_data[23:16] = 8'h3C;
        req = 4'b0100;
        tick;  // t7
        checks++;
        if (tx_err !== 1'b0 || ack !== 4'b0100 || tx_transmit !== 1'b1) begin
            errors++; $display("FAIL to_reserve: got tx_err=%b ack=%b transmit=%b expected 0 0100 1", tx_err, ack, tx_transmit);
        end
        req = '0;
        wait_frame_done(20, cyc);
        checks++; if (cyc !== 13) begin errors++; $display("FAIL to_reserve_done: got %0d expected 13", cyc); end
    endtask

    task automatic test_reset_mid_frame;
        int cyc;
        do_reset;
        req_data[15:8] = 8'h5A;
        req = 4'b0100;
        tick;  // t1
        req = '0;
        for (int t = 2; t <= 6; t++) tick;
        reset = 1'b1;
        #1;
        checks++;
        if (ack !== 4'b0000 || tx_transmit !== 1'b0 || tx_data !== 8'h00 || active_id !== 2'd0 || frame_done !== 1'b0 || tx_err !== 1'b0) begin
            errors++; $display("FAIL midreset_outputs: got ack=%b tr=%b data=%h id=%0d fd=%b err=%b expected all 0",
                               ack, tx_transmit, tx_data, active_id, frame_done, tx_err);
        end
        tick;
        reset = 1'b0;
        req = 4'b0010;
        wait_frame_done(30, cyc);
        checks++; if (cyc !== 14) begin errors++; $display("FAIL midreset_frame_done: got %0d expected 14", cyc); end
        checks++; if (active_id !== 2'd1 || tx_data !== 8'h5A) begin
            errors++; $display("FAIL midreset_client: got id=%0d data=%h expected 1 5a", active_id, tx_data);
        end
        req = '0;
    endtask

    initial begin
        test_reset;
        test_single;
        test_round_robin;
        test_fairness_wrap;
        test_busy_gating;
        test_timeout;
        test_reset_mid_frame;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
